counter_modn: RTL and testbench

- Parametrised modulo-N up/down counter, the successor to the fixed 0..7 wrap counter.
- Adds count enable, direction, synchronous load and a terminal-count output for cascading.
- It is the building block for the wall-clock time base: seconds (mod 60) feed minutes (mod 60), which feed hours (mod 24). Each stage's `tc` drives the next stage's `en`.
- Optional registered BCD digit outputs drive the 7-segment display path directly.

---
 rtl/counter_modn.sv | 204 ++++++++++++++++++++
 tb/tb_counter_modn.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_modn.sv
// -----------------------------------------------------------------------------
// counter_modn
//
// Parametrised modulo-N up/down counter with count enable, synchronous load
// and a combinational terminal-count output for zero-latency cascading
// (seconds -> minutes -> hours time base).
//
// Parameters
//   WIDTH     : width of count / load_val (2**WIDTH >= MODULUS)
//   MODULUS   : count range 0 .. MODULUS-1 (2 .. 2**WIDTH)
//   RESET_VAL : value taken on reset (< MODULUS)
//
// Ports
//   clk       in   system clock, all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   en        in   count enable, one step per enabled cycle
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   synchronous load strobe (beats en)
//   load_val  in   value to load, clamped to MODULUS-1 when out of range
//   count     out  current count (registered)
//   tc        out  terminal count, high in the cycle before a wrap edge
//
// Optional feature (macro COUNTER_MODN_BCD_EN)
//   bcd_tens  out  registered tens digit of count
//   bcd_ones  out  registered ones digit of count
//   Requires MODULUS <= 100.
// -----------------------------------------------------------------------------
module counter_modn #(
    parameter int WIDTH     = 6,
    parameter int MODULUS   = 60,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
`ifdef COUNTER_MODN_BCD_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    // Largest legal count. MODULUS-1 always fits in WIDTH bits, even when
    // MODULUS = 2**WIDTH, so every compare below stays in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_W   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("counter_modn: WIDTH must be in 1..31");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("counter_modn: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("counter_modn: RESET_VAL must be < MODULUS");
    end

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_out_of_range;
    logic             w_tc;

    // Decode the current count. Out-of-range values are only reachable by
    // corruption; they are folded into the wrap paths so one enabled cycle
    // restores a legal value.
    always_comb begin
        w_at_max       = (r_count == MAX_VAL);
        w_at_zero      = (r_count == ZERO_W);
        w_out_of_range = (r_count > MAX_VAL);
    end

    // Clamp the load value to the top of the range.
    always_comb begin
        if (load_val > MAX_VAL) begin
            w_load_clamped = MAX_VAL;
        end else begin
            w_load_clamped = load_val;
        end
    end

    // Next-state selection with priority reset > load > en > hold. The
    // wrap compare happens before the add/subtract, so the arithmetic never
    // has to represent MODULUS itself.
    always_comb begin
        w_count_next = r_count;
        if (reset) begin
            w_count_next = RESET_W;
        end else if (load) begin
            w_count_next = w_load_clamped;
        end else if (en) begin
            if (up) begin
                if (w_at_max || w_out_of_range) begin
                    w_count_next = ZERO_W;
                end else begin
                    w_count_next = r_count + ONE_W;
                end
            end else begin
                if (w_at_zero || w_out_of_range) begin
                    w_count_next = MAX_VAL;
                end else begin
                    w_count_next = r_count - ONE_W;
                end
            end
        end else begin
            w_count_next = r_count;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_W;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Terminal count: high in the cycle before the wrap edge so that a
    // downstream stage with en = tc steps on the very edge this stage wraps.
    // Kept combinational for zero latency through a cascade.
    always_comb begin
        if (reset || load || !en) begin
            w_tc = 1'b0;
        end else if (up) begin
            w_tc = w_at_max;
        end else begin
            w_tc = w_at_zero;
        end
    end

    assign count = r_count;
    assign tc    = w_tc;

`ifdef COUNTER_MODN_BCD_EN
    // -------------------------------------------------------------------------
    // Registered BCD digits, derived from the next-state value so they move
    // on the same edge as count.
    // -------------------------------------------------------------------------
    if (MODULUS > 100) begin : g_bad_bcd_modulus
        $error("counter_modn: COUNTER_MODN_BCD_EN requires MODULUS <= 100");
    end

    // Shift-add-3 (double dabble) binary to two-digit BCD. Values are < 100,
    // so nothing significant is ever shifted out of the 8-bit accumulator.
    function automatic logic [7:0] bin_to_bcd(input logic [WIDTH-1:0] bin);
        logic [7:0] acc;
        acc = 8'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (acc[3:0] >= 4'd5) begin
                acc[3:0] = acc[3:0] + 4'd3;
            end else begin
                acc[3:0] = acc[3:0];
            end
            if (acc[7:4] >= 4'd5) begin
                acc[7:4] = acc[7:4] + 4'd3;
            end else begin
                acc[7:4] = acc[7:4];
            end
            acc = {acc[6:0], bin[i]};
        end
        return acc;
    endfunction

    logic [7:0] w_bcd_next;
    logic [3:0] r_bcd_tens;
    logic [3:0] r_bcd_ones;

    // Convert the value the counter is about to take.
    always_comb begin
        w_bcd_next = bin_to_bcd(w_count_next);
    end

    // Digit registers, reset to the digits of RESET_VAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd_tens <= 4'(RESET_VAL / 10);
            r_bcd_ones <= 4'(RESET_VAL % 10);
        end else begin
            r_bcd_tens <= w_bcd_next[7:4];
            r_bcd_ones <= w_bcd_next[3:0];
        end
    end

    assign bcd_tens = r_bcd_tens;
    assign bcd_ones = r_bcd_ones;
`endif

endmodule

// File: tb/tb_counter_modn.sv
// -----------------------------------------------------------------------------
// tb_counter_modn
//
// Directed, self-checking bench for counter_modn. Several instances cover the
// different parameter sets: mod 60 (general), mod 24 (down wrap), mod 60 with
// RESET_VAL = 12 (reset priority), a sec/min/hour cascade, and mod 16 with
// WIDTH = 4 (full range).
// -----------------------------------------------------------------------------
module tb_counter_modn;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH 6, MODULUS 60, RESET_VAL 0
    logic       a_en, a_up, a_load, a_tc;
    logic [5:0] a_val, a_count;
    // Instance B: WIDTH 5, MODULUS 24
    logic       b_en, b_up, b_load, b_tc;
    logic [4:0] b_val, b_count;
    // Instance C: WIDTH 6, MODULUS 60, RESET_VAL 12
    logic       c_en, c_up, c_load, c_tc;
    logic [5:0] c_val, c_count;
    // Instance D: WIDTH 4, MODULUS 16
    logic       d_en, d_up, d_load, d_tc;
    logic [3:0] d_val, d_count;
    // Cascade sec (60) -> min (60) -> hour (24)
    logic       cs_en, cs_load;
    logic [5:0] sec_val, min_val, sec_count, min_count;
    logic [4:0] hr_val, hr_count;
    logic       sec_tc, min_tc, hr_tc;

`ifdef COUNTER_MODN_BCD_EN
    logic [3:0] a_tens, a_ones, b_tens, b_ones, c_tens, c_ones, d_tens, d_ones;
    logic [3:0] s_tens, s_ones, m_tens, m_ones, h_tens, h_ones;
`endif

    counter_modn #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_a (
        .clk(clk), .reset(rst), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_val), .count(a_count), .tc(a_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(a_tens), .bcd_ones(a_ones)
`endif
    );

    counter_modn #(.WIDTH(5), .MODULUS(24), .RESET_VAL(0)) u_b (
        .clk(clk), .reset(rst), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_val), .count(b_count), .tc(b_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(b_tens), .bcd_ones(b_ones)
`endif
    );

    counter_modn #(.WIDTH(6), .MODULUS(60), .RESET_VAL(12)) u_c (
        .clk(clk), .reset(rst), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_val), .count(c_count), .tc(c_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(c_tens), .bcd_ones(c_ones)
`endif
    );

    counter_modn #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_d (
        .clk(clk), .reset(rst), .en(d_en), .up(d_up), .load(d_load),
        .load_val(d_val), .count(d_count), .tc(d_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(d_tens), .bcd_ones(d_ones)
`endif
    );

    counter_modn #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_sec (
        .clk(clk), .reset(rst), .en(cs_en), .up(1'b1), .load(cs_load),
        .load_val(sec_val), .count(sec_count), .tc(sec_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(s_tens), .bcd_ones(s_ones)
`endif
    );

    counter_modn #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_min (
        .clk(clk), .reset(rst), .en(sec_tc), .up(1'b1), .load(cs_load),
        .load_val(min_val), .count(min_count), .tc(min_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(m_tens), .bcd_ones(m_ones)
`endif
    );

    counter_modn #(.WIDTH(5), .MODULUS(24), .RESET_VAL(0)) u_hr (
        .clk(clk), .reset(rst), .en(min_tc), .up(1'b1), .load(cs_load),
        .load_val(hr_val), .count(hr_count), .tc(hr_tc)
`ifdef COUNTER_MODN_BCD_EN
        , .bcd_tens(h_tens), .bcd_ones(h_ones)
`endif
    );

    // One comparison: counts it, reports and counts a failure.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_val = 6'd0;
        b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_val = 5'd0;
        c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_val = 6'd0;
        d_en = 1'b0; d_up = 1'b1; d_load = 1'b0; d_val = 4'd0;
        cs_en = 1'b0; cs_load = 1'b0; sec_val = 6'd0; min_val = 6'd0; hr_val = 5'd0;

        // ---- reset ----
        step();
        step();
        chk("reset_a_count", 32'(a_count), 32'd0);
        chk("reset_c_count", 32'(c_count), 32'd12);
`ifdef COUNTER_MODN_BCD_EN
        chk("reset_c_tens", 32'(c_tens), 32'd1);
        chk("reset_c_ones", 32'(c_ones), 32'd2);
`endif
        // reset beats load/en; a at 0 counting down would otherwise give tc
        a_en = 1'b1; a_up = 1'b0;
        c_load = 1'b1; c_val = 6'd30; c_en = 1'b1;
        #1;
        chk("reset_a_tc_masked", 32'(a_tc), 32'd0);
        chk("reset_c_tc", 32'(c_tc), 32'd0);
        step();
        chk("reset_prio_c_count", 32'(c_count), 32'd12);
        chk("reset_prio_a_count", 32'(a_count), 32'd0);

        rst = 1'b0;
        a_en = 1'b0; a_up = 1'b1;
        c_load = 1'b0;
        step();
        chk("c_after_reset_inc", 32'(c_count), 32'd13);
        c_en = 1'b0;

        // ---- up-count 61 cycles on mod 60 ----
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 0; i < 61; i++) begin
            #1;
            chk("up_count", 32'(a_count), 32'(i % 60));
            chk("up_tc", 32'(a_tc), ((i % 60) == 59) ? 32'd1 : 32'd0);
`ifdef COUNTER_MODN_BCD_EN
            chk("up_tens", 32'(a_tens), 32'((i % 60) / 10));
            chk("up_ones", 32'(a_ones), 32'((i % 60) % 10));
`endif
            step();
        end
        chk("up_after_61", 32'(a_count), 32'd1);

        // ---- load and clamp ----
        a_load = 1'b1; a_val = 6'd45;
        step();
        chk("load_45", 32'(a_count), 32'd45);
        a_val = 6'd63;
        step();
        chk("load_clamp_63", 32'(a_count), 32'd59);
        #1;
        chk("load_masks_tc", 32'(a_tc), 32'd0);
        a_val = 6'd60;
        step();
        chk("load_clamp_60", 32'(a_count), 32'd59);
        a_load = 1'b0;
        #1;
        chk("tc_at_59", 32'(a_tc), 32'd1);
        step();
        chk("wrap_59_to_0", 32'(a_count), 32'd0);
        // hold
        a_en = 1'b0;
        step();
        chk("hold_0", 32'(a_count), 32'd0);
        // direction change: down from 0 on mod 60
        a_en = 1'b1; a_up = 1'b0;
        #1;
        chk("down_tc_at_0", 32'(a_tc), 32'd1);
        step();
        chk("down_wrap_60", 32'(a_count), 32'd59);
        a_up = 1'b1;
        step();
        chk("dir_change_up", 32'(a_count), 32'd0);
        a_en = 1'b0;

        // ---- mod 24 down wrap ----
        b_en = 1'b1; b_up = 1'b0;
        #1;
        chk("m24_tc_at_0", 32'(b_tc), 32'd1);
        step();
        chk("m24_down_wrap", 32'(b_count), 32'd23);
        chk("m24_tc_at_23_down", 32'(b_tc), 32'd0);
        b_up = 1'b1;
        #1;
        chk("m24_tc_at_23_up", 32'(b_tc), 32'd1);
        step();
        chk("m24_up_wrap", 32'(b_count), 32'd0);
        b_en = 1'b0; b_up = 1'b0;
        #1;
        chk("m24_hold_tc", 32'(b_tc), 32'd0);
        step();
        chk("m24_hold_count", 32'(b_count), 32'd0);

        // ---- cascade 23:59:58 -> 00:00:00 ----
        cs_load = 1'b1; sec_val = 6'd58; min_val = 6'd59; hr_val = 5'd23;
        step();
        cs_load = 1'b0; cs_en = 1'b1;
        chk("cas_load_sec", 32'(sec_count), 32'd58);
        chk("cas_load_min", 32'(min_count), 32'd59);
        chk("cas_load_hr", 32'(hr_count), 32'd23);
        #1;
        chk("cas_hr_tc_at_58", 32'(hr_tc), 32'd0);
        step();
        chk("cas_sec_59", 32'(sec_count), 32'd59);
        chk("cas_min_hold", 32'(min_count), 32'd59);
        chk("cas_min_tc", 32'(min_tc), 32'd1);
        chk("cas_hr_tc", 32'(hr_tc), 32'd1);
        step();
        chk("cas_sec_wrap", 32'(sec_count), 32'd0);
        chk("cas_min_wrap", 32'(min_count), 32'd0);
        chk("cas_hr_wrap", 32'(hr_count), 32'd0);
        chk("cas_hr_tc_drop", 32'(hr_tc), 32'd0);
        step();
        chk("cas_sec_1", 32'(sec_count), 32'd1);
        chk("cas_min_still_0", 32'(min_count), 32'd0);
        cs_en = 1'b0;

        // ---- full range WIDTH 4 / MODULUS 16 ----
        d_load = 1'b1; d_val = 4'd15;
        step();
        d_load = 1'b0; d_en = 1'b1; d_up = 1'b1;
        chk("m16_load_15", 32'(d_count), 32'd15);
        #1;
        chk("m16_tc_15", 32'(d_tc), 32'd1);
        step();
        chk("m16_wrap_up", 32'(d_count), 32'd0);
        d_up = 1'b0;
        #1;
        chk("m16_tc_0_down", 32'(d_tc), 32'd1);
        step();
        chk("m16_wrap_down", 32'(d_count), 32'd15);
        step();
        chk("m16_down_14", 32'(d_count), 32'd14);
        d_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
